// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU: opcode values,
// FSM state encoding and small decode helpers.
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_JZ    = 4'd1;
  localparam logic [3:0] OP_IMM   = 4'd2;
  localparam logic [3:0] OP_MOVE  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_SL    = 4'd10;
  localparam logic [3:0] OP_SR    = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_ADDI  = 4'd13;
  localparam logic [3:0] OP_RSVD  = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // Width of a register-index field inside the MOVE immediate.
  function automatic int calc_rw(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  // STORE, LOAD and the memory-operand ALU ops all go through the MEM state.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_STORE) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/acc_cpu_mc_if.sv
// Instruction and data memory handshake bundle between the CPU (master)
// and the memory instances (slave).
interface acc_cpu_mc_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: produces the new r0 value for every
// opcode that writes the accumulator.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int SW     = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        opcode,
  input  logic [SW-1:0]     shamt,
  output logic [DATA_W-1:0] result
);

  // Result select; anything not listed leaves the accumulator unchanged.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    result = acc;
    case (opcode)
      OP_IMM, OP_LOAD:  result = operand;
      OP_ADD, OP_ADDI:  result = acc + operand;
      OP_AND:           result = acc & operand;
      OP_OR:            result = acc | operand;
      OP_XOR:           result = acc ^ operand;
      OP_SL:            result = acc << shamt;
      OP_SR:            result = acc >> shamt;
      default:          result = acc;
    endcase
  end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer,
// register file (r0 acc, r1 offset, r2 sp, r3+ scratch) and program counter.
module acc_cpu_mc
  import acc_cpu_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          NREG     = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_cpu_mc_if.master      bus,
  output logic              halted,
  output logic [DATA_W-1:0] acc_out
);

  localparam int RW = calc_rw(NREG);
  localparam int IW = DATA_W - 4;
  localparam int SW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] PC_RST = DATA_W'(RESET_PC);
  localparam logic [DATA_W-1:0] PC_INC = DATA_W'(PC_STEP);

  state_t            state, next_state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] ea;
  logic [DATA_W-1:0] pc_seq;
  logic [DATA_W-1:0] alu_operand;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mv_src;
  logic [RW-1:0]     mv_a, mv_b;
  logic [SW-1:0]     shamt;

  logic              wr_en;
  logic [RW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign opcode      = ir[DATA_W-1:DATA_W-4];
  assign imm         = {4'b0000, ir[IW-1:0]};
  assign ea          = imm + regs[1];
  assign pc_seq      = pc + PC_INC;
  assign mv_a        = ir[2*RW-1:RW];
  assign mv_b        = ir[RW-1:0];
  assign shamt       = ir[SW-1:0];
  assign mv_src      = (int'(mv_b) < NREG) ? regs[mv_b] : '0;
  assign alu_operand = is_mem_op(opcode) ? mdr : imm;

  assign bus.imem_addr = pc;
  assign halted        = (state == ST_HALT);
  assign acc_out       = regs[0];

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .acc     (regs[0]),
    .operand (alu_operand),
    .opcode  (opcode),
    .shamt   (shamt),
    .result  (alu_result)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= ST_FETCH;
    else        state <= next_state;
  end

  // Next-state decode; acks only count while our own request is up.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  if (bus.imem_req && bus.imem_ack) next_state = ST_DECODE;
      ST_DECODE: begin
        if (is_mem_op(opcode))      next_state = ST_MEM;
        else if (opcode == OP_HALT) next_state = ST_HALT;
        else                        next_state = ST_EXEC;
      end
      ST_EXEC:   next_state = ST_FETCH;
      ST_MEM:    if (bus.dmem_req && bus.dmem_ack) next_state = ST_WB;
      ST_WB:     next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_FETCH;
    endcase
  end

  // Registered bus requests, held-stable data-access fields, IR and MDR capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_req   <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      ir             <= '0;
      mdr            <= '0;
    end else begin
      bus.imem_req <= (next_state == ST_FETCH);
      bus.dmem_req <= (next_state == ST_MEM);
      bus.dmem_we  <= (next_state == ST_MEM) && (opcode == OP_STORE);
      if (state == ST_DECODE && next_state == ST_MEM) begin
        bus.dmem_addr  <= ea;
        bus.dmem_wdata <= regs[0];
      end
      if (state == ST_FETCH && bus.imem_req && bus.imem_ack) ir  <= bus.imem_rdata;
      if (state == ST_MEM && bus.dmem_req && bus.dmem_ack)   mdr <= bus.dmem_rdata;
    end
  end

  // Program counter: jumps resolve in EXEC, everything else steps sequentially.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RST;
    end else if (state == ST_EXEC) begin
      case (opcode)
        OP_JZ:   pc <= (regs[0] == '0) ? imm : pc_seq;
        OP_JMP:  pc <= imm;
        default: pc <= pc_seq;
      endcase
    end else if (state == ST_WB) begin
      pc <= pc_seq;
    end
  end

  // Register-file write port selection for EXEC and WB.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = alu_result;
    if (state == ST_EXEC) begin
      case (opcode)
        OP_IMM, OP_SL, OP_SR, OP_ADDI: wr_en = 1'b1;
        OP_MOVE: begin
          wr_en   = (int'(mv_a) < NREG);
          wr_idx  = mv_a;
          wr_data = mv_src;
        end
        OP_NOP, OP_RSVD, OP_JZ, OP_JMP: wr_en = 1'b0;
        default: wr_en = 1'b0;
      endcase
    end else if (state == ST_WB) begin
      wr_en = (opcode != OP_STORE);
    end
  end

  // Register file.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is a small bank of flops, not a RAM, so it is legal and required to clear it on reset.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Self-checking bench for acc_cpu_mc: directed programs plus random programs
// compared against an instruction-level reference interpreter.
module tb_acc_cpu_mc;
  import acc_cpu_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          halted;
  logic [DW-1:0] acc_out;

  always #5 clk = ~clk;

  acc_cpu_mc_if #(.DATA_W(DW)) bus ();

  acc_cpu_mc #(.DATA_W(DW), .NREG(4), .RESET_PC(0), .PC_STEP(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .halted  (halted),
    .acc_out (acc_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- memories and responder ----------------
  logic [15:0]     imem [256];
  bit   [15:0]     dmem_mem [bit [15:0]];
  logic [15:0]     seed = 16'h1357;

  int              iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  bit              rand_waits = 0, spurious = 0;
  int              dreq_len = 0, dreq_max = 0;
  logic [15:0]     dreq_addr = '0;
  bit              addr_unstable = 0, overlap = 0;
  logic [31:0]     wlog [$];
  logic [15:0]     flog [$];

  function automatic logic [15:0] dmem_init(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A ^ seed;
  endfunction

  function automatic logic [15:0] dmem_rd(input logic [15:0] a);
    return dmem_mem.exists(a) ? dmem_mem[a] : dmem_init(a);
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] im);
    return {op, im};
  endfunction

  // Memory responder: decides acks on the falling edge, DUT samples on the rising edge.
  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        icnt = 0; dcnt = 0; dreq_len = 0;
      end else begin
        if (bus.imem_req && bus.dmem_req) overlap = 1;
        if (bus.imem_req) begin
          if (icnt >= iwait) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = imem[bus.imem_addr[7:0]];
            flog.push_back(bus.imem_addr);
            icnt = 0;
            if (rand_waits) iwait = $urandom_range(0, 3);
          end else begin
            bus.imem_ack = 1'b0;
            icnt++;
          end
        end else begin
          icnt = 0;
          bus.imem_ack   = spurious && ($urandom_range(0, 3) == 0);
          bus.imem_rdata = 16'($urandom);
        end
        if (bus.dmem_req) begin
          if (dreq_len == 0) dreq_addr = bus.dmem_addr;
          else if (bus.dmem_addr !== dreq_addr) addr_unstable = 1;
          dreq_len++;
          if (dreq_len > dreq_max) dreq_max = dreq_len;
          if (dcnt >= dwait) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = dmem_rd(bus.dmem_addr);
            if (bus.dmem_we) begin
              dmem_mem[bus.dmem_addr] = bus.dmem_wdata;
              wlog.push_back({bus.dmem_addr, bus.dmem_wdata});
            end
            dcnt = 0;
            if (rand_waits) dwait = $urandom_range(0, 3);
          end else begin
            bus.dmem_ack = 1'b0;
            dcnt++;
          end
        end else begin
          dreq_len = 0; dcnt = 0;
          bus.dmem_ack   = spurious && ($urandom_range(0, 3) == 0);
          bus.dmem_rdata = 16'($urandom);
        end
      end
    end
  end

  // ---------------- reference interpreter ----------------
  logic [15:0] m_r [4];
  logic [15:0] m_pc;
  int          m_cycles;
  logic [31:0] m_wlog [$];
  bit   [15:0] m_dmem [bit [15:0]];

  task automatic model_run();
    logic [15:0] w, im, ea, md, nxt;
    logic [3:0]  op;
    for (int k = 0; k < 4; k++) m_r[k] = '0;
    m_pc = '0; m_cycles = 1; m_wlog.delete(); m_dmem.delete();
    for (int step = 0; step < 2000; step++) begin
      w  = imem[m_pc[7:0]];
      op = w[15:12];
      im = {4'h0, w[11:0]};
      ea = im + m_r[1];
      md = m_dmem.exists(ea) ? m_dmem[ea] : dmem_init(ea);
      if (op == 4'd15) begin
        m_cycles += 2;
        break;
      end
      m_cycles += (op >= 4'd4 && op <= 4'd9) ? 4 : 3;
      nxt = m_pc + 16'd1;
      case (op)
        4'd1:  if (m_r[0] == 16'd0) nxt = im;
        4'd2:  m_r[0] = im;
        4'd3:  m_r[im[3:2]] = m_r[im[1:0]];
        4'd4:  begin m_dmem[ea] = m_r[0]; m_wlog.push_back({ea, m_r[0]}); end
        4'd5:  m_r[0] = md;
        4'd6:  m_r[0] = m_r[0] + md;
        4'd7:  m_r[0] = m_r[0] & md;
        4'd8:  m_r[0] = m_r[0] | md;
        4'd9:  m_r[0] = m_r[0] ^ md;
        4'd10: m_r[0] = m_r[0] << im[3:0];
        4'd11: m_r[0] = m_r[0] >> im[3:0];
        4'd12: nxt = im;
        4'd13: m_r[0] = m_r[0] + im;
        default: ;
      endcase
      m_pc = nxt;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic start_prog(input int iw, input int dw, input bit rnd);
    rst_n = 1'b0;
    iwait = iw; dwait = dw; rand_waits = rnd; spurious = rnd;
    wlog.delete(); flog.delete(); dreq_max = 0; addr_unstable = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, output int cyc);
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (halted) break;
    end
    check({tag, "_halted"}, halted, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int len;
    logic [3:0]  op;
    logic [11:0] im;

    clear_imem();
    #1 rst_n = 1'b0;
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_dmem_we",  bus.dmem_we, 0);
    check("rst_halted",   halted, 0);
    check("rst_acc",      acc_out, 0);
    check("rst_pc",       bus.imem_addr, 0);

    // 1: IMM 5; ADDI 3; HALT with zero-wait memories.
    clear_imem();
    imem[0] = ins(4'd2, 12'h005); imem[1] = ins(4'd13, 12'h003); imem[2] = ins(4'd15, 12'h000);
    start_prog(0, 0, 0);
    wait_halt("t1", cyc);
    check("t1_cycles", cyc, 9);
    check("t1_acc", acc_out, 16'h0008);
    check("t1_pc", bus.imem_addr, 16'h0002);

    // 2: r1=0x10, STORE at EA 0x12, then LOAD it back.
    clear_imem();
    imem[0] = ins(4'd2, 12'h010); imem[1] = ins(4'd3, 12'h004);
    imem[2] = ins(4'd2, 12'h0AB); imem[3] = ins(4'd4, 12'h002);
    imem[4] = ins(4'd2, 12'h000); imem[5] = ins(4'd5, 12'h002);
    imem[6] = ins(4'd15, 12'h000);
    start_prog(0, 0, 0);
    wait_halt("t2", cyc);
    check("t2_nwrites", wlog.size(), 1);
    if (wlog.size() >= 1) check("t2_write", wlog[0], {16'h0012, 16'h00AB});
    check("t2_acc", acc_out, 16'h00AB);

    // 3: ADD with 3 wait states, wrapping 0x0002 + 0xFFFF.
    clear_imem();
    dmem_mem.delete();
    dmem_mem[16'h0005] = 16'hFFFF;
    imem[0] = ins(4'd2, 12'h002); imem[1] = ins(4'd6, 12'h005); imem[2] = ins(4'd15, 12'h000);
    start_prog(0, 3, 0);
    wait_halt("t3", cyc);
    check("t3_dreq_len", dreq_max, 4);
    check("t3_addr_stable", addr_unstable, 0);
    check("t3_acc", acc_out, 16'h0001);

    // 4: JZ taken and not taken.
    clear_imem();
    imem[0] = ins(4'd1, 12'h020);
    start_prog(0, 0, 0);
    wait_halt("t4a", cyc);
    check("t4a_nfetch", flog.size(), 2);
    if (flog.size() >= 2) check("t4a_target", flog[1], 16'h0020);
    check("t4a_pc", bus.imem_addr, 16'h0020);
    clear_imem();
    imem[0] = ins(4'd2, 12'h001); imem[1] = ins(4'd1, 12'h020);
    start_prog(0, 0, 0);
    wait_halt("t4b", cyc);
    check("t4b_pc", bus.imem_addr, 16'h0002);

    // 5: shifts and register moves through r2/r3.
    clear_imem();
    imem[0] = ins(4'd2, 12'hF0F); imem[1] = ins(4'd10, 12'h004);
    start_prog(0, 0, 0);
    wait_halt("t5a", cyc);
    check("t5a_sl", acc_out, 16'hF0F0);
    imem[2] = ins(4'd11, 12'h00F);
    start_prog(0, 0, 0);
    wait_halt("t5b", cyc);
    check("t5b_sr", acc_out, 16'h0001);
    clear_imem();
    dmem_mem[16'h0040] = 16'h1234;
    imem[0] = ins(4'd5, 12'h040); imem[1] = ins(4'd3, 12'h008);
    imem[2] = ins(4'd2, 12'h000); imem[3] = ins(4'd3, 12'h00E);
    imem[4] = ins(4'd2, 12'h000); imem[5] = ins(4'd3, 12'h003);
    start_prog(0, 0, 0);
    wait_halt("t5c", cyc);
    check("t5c_r3", acc_out, 16'h1234);

    // 6: asynchronous reset in the middle of a data access.
    clear_imem();
    dmem_mem[16'h0030] = 16'hBEEF;
    imem[0] = ins(4'd2, 12'h007); imem[1] = ins(4'd5, 12'h030);
    start_prog(0, 20, 0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.dmem_req) break;
    end
    check("t6_dreq_seen", bus.dmem_req, 1);
    check("t6_acc_before", acc_out, 16'h0007);
    #2 rst_n = 1'b0;
    #1;
    check("t6_dreq_clr", bus.dmem_req, 0);
    check("t6_ireq_clr", bus.imem_req, 0);
    check("t6_pc_rst", bus.imem_addr, 16'h0000);
    check("t6_acc_rst", acc_out, 16'h0000);
    flog.delete();
    dwait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt("t6", cyc);
    check("t6_refetch", (flog.size() > 0) ? flog[0] : 16'hFFFF, 16'h0000);
    check("t6_acc", acc_out, 16'hBEEF);

    // Random programs against the reference interpreter.
    for (int p = 0; p < 16; p++) begin
      clear_imem();
      dmem_mem.delete();
      seed = 16'($urandom);
      len = $urandom_range(8, 24);
      for (int i = 0; i < len - 1; i++) begin
        op = 4'($urandom_range(0, 14));
        im = 12'($urandom);
        if (op == 4'd1 || op == 4'd12) im = 12'($urandom_range(i + 1, len - 1));
        imem[i] = ins(op, im);
      end
      model_run();
      start_prog(0, 0, p[0]);
      wait_halt($sformatf("rnd%0d", p), cyc);
      check($sformatf("rnd%0d_acc", p), acc_out, m_r[0]);
      check($sformatf("rnd%0d_pc", p), bus.imem_addr, m_pc);
      if (!p[0]) check($sformatf("rnd%0d_cycles", p), cyc, m_cycles);
      check($sformatf("rnd%0d_nwrites", p), wlog.size(), m_wlog.size());
      for (int i = 0; i < wlog.size() && i < m_wlog.size(); i++)
        check($sformatf("rnd%0d_write%0d", p, i), wlog[i], m_wlog[i]);
      check($sformatf("rnd%0d_addr_stable", p), addr_unstable, 0);
    end

    check("no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
